// File: rtl/div_unit.sv
// ---------------------------------------------------------------------------
// div_unit
//   Iterative 32-step radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
//   Operates on operand magnitudes and applies sign correction at the end.
//   A zero divisor and signed overflow bypass the iteration and complete on
//   the accept edge.
//
// Ports
//   clk     in   rising-edge clock
//   rst     in   asynchronous active-high reset
//   start   in   divide request (sampled in IDLE only)
//   funct3  in   100 DIV, 101 DIVU, 110 REM, 111 REMU, other -> DIVU
//   src_a   in   dividend
//   src_b   in   divisor
//   rd_in   in   destination register tag
//   flush   in   abort in-flight operation (beats start and ack)
//   ack     in   writeback accepts the result
//   busy    out  state is not IDLE
//   done    out  result valid
//   result  out  quotient or remainder, held until the next result
//   rd_out  out  destination tag of the delivered result
// ---------------------------------------------------------------------------
module div_unit #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [2:0]            funct3,
    input  logic [DATA_WIDTH-1:0] src_a,
    input  logic [DATA_WIDTH-1:0] src_b,
    input  logic [4:0]            rd_in,
    input  logic                  flush,
    input  logic                  ack,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] result,
    output logic [4:0]            rd_out
);

    localparam int unsigned W = DATA_WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state_q;
    logic [5:0]     cnt_q;
    logic [W-1:0]   rem_q;      // partial remainder (always < divisor)
    logic [W-1:0]   quo_q;      // dividend shifts out, quotient shifts in
    logic [W-1:0]   dvsr_q;     // divisor magnitude
    logic           is_rem_q;
    logic           neg_quo_q;
    logic           neg_rem_q;
    logic [4:0]     tag_q;      // tag of the operation in flight
    logic           busy_q;
    logic           done_q;
    logic [W-1:0]   result_q;
    logic [4:0]     rd_out_q;

    // ------------------------------------------------------------------
    // Operand decode at accept time
    // ------------------------------------------------------------------
    logic           op_signed;
    logic           op_rem;
    logic           a_neg;
    logic           b_neg;
    logic [W-1:0]   a_mag;
    logic [W-1:0]   b_mag;
    logic           div_zero;
    logic           sgn_ovf;
    logic [W-1:0]   spec_result;

    always_comb begin
        op_signed   = (funct3 == 3'b100) || (funct3 == 3'b110);
        op_rem      = (funct3 == 3'b110) || (funct3 == 3'b111);
        a_neg       = op_signed && src_a[W-1];
        b_neg       = op_signed && src_b[W-1];
        // Negating the most negative value yields the same bit pattern,
        // which is already the correct unsigned magnitude.
        a_mag       = a_neg ? (~src_a + 1'b1) : src_a;
        b_mag       = b_neg ? (~src_b + 1'b1) : src_b;
        div_zero    = (src_b == '0);
        sgn_ovf     = op_signed && (src_a == {1'b1, {(W-1){1'b0}}}) && (src_b == '1);
        spec_result = '0;
        if (div_zero) begin
            spec_result = op_rem ? src_a : '1;
        end else if (sgn_ovf) begin
            spec_result = op_rem ? '0 : {1'b1, {(W-1){1'b0}}};
        end
    end

    // ------------------------------------------------------------------
    // One restoring shift-subtract step and final sign correction
    // ------------------------------------------------------------------
    logic [W:0]     rem_sh;
    logic [W:0]     trial;
    logic           sub_ok;
    logic [W-1:0]   rem_d;
    logic [W-1:0]   quo_d;
    logic [W-1:0]   result_d;

    always_comb begin
        rem_sh = {rem_q, quo_q[W-1]};
        trial  = rem_sh - {1'b0, dvsr_q};
        // A borrow into the top bit means the divisor did not fit.
        sub_ok = ~trial[W];
        rem_d  = sub_ok ? trial[W-1:0] : rem_sh[W-1:0];
        quo_d  = {quo_q[W-2:0], sub_ok};
        if (is_rem_q) begin
            result_d = neg_rem_q ? (~rem_q + 1'b1) : rem_q;
        end else begin
            result_d = neg_quo_q ? (~quo_q + 1'b1) : quo_q;
        end
    end

    // ------------------------------------------------------------------
    // Control FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvsr_q    <= '0;
            is_rem_q  <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            tag_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            result_q  <= '0;
            rd_out_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start && !flush) begin
                        tag_q     <= rd_in;
                        is_rem_q  <= op_rem;
                        neg_quo_q <= a_neg ^ b_neg;
                        neg_rem_q <= a_neg;
                        dvsr_q    <= b_mag;
                        quo_q     <= a_mag;
                        rem_q     <= '0;
                        cnt_q     <= '0;
                        busy_q    <= 1'b1;
                        if (div_zero || sgn_ovf) begin
                            state_q  <= DONE;
                            done_q   <= 1'b1;
                            result_q <= spec_result;
                            rd_out_q <= rd_in;
                        end else begin
                            state_q  <= CALC;
                        end
                    end
                end

                CALC: begin
                    if (flush) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        cnt_q   <= '0;
                    end else if (cnt_q == 6'(W)) begin
                        // All steps finished; this cycle only applies signs.
                        state_q  <= DONE;
                        done_q   <= 1'b1;
                        result_q <= result_d;
                        rd_out_q <= tag_q;
                        cnt_q    <= '0;
                    end else begin
                        rem_q <= rem_d;
                        quo_q <= quo_d;
                        cnt_q <= cnt_q + 6'd1;
                    end
                end

                DONE: begin
                    if (flush || ack) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b0;
                    end
                end

                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign rd_out = rd_out_q;

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 The block SHALL have one parameter: DATA_WIDTH, default 32, operand and result width; only 32 is required to be supported.
REQ-002 The block SHALL have one clock; reset is asynchronous and active-high, with ports named clk and rst.
REQ-003 Port clk  input  1  rising-edge clock.
REQ-004 Port rst  input  1  asynchronous active-high reset.
REQ-005 Port start  input  1  divide request from decode (its is_div); sampled on the rising edge.
REQ-006 Port funct3  input  3  operation: 100 DIV, 101 DIVU, 110 REM, 111 REMU; any other code is treated as DIVU.
REQ-007 Port src_a  input  DATA_WIDTH  dividend (register rs1 value).
REQ-008 Port src_b  input  DATA_WIDTH  divisor (register rs2 value).
REQ-009 Port rd_in  input  5  destination register tag.
REQ-010 Port flush  input  1  abort the in-flight operation.
REQ-011 Port ack  input  1  writeback accepts the result this cycle.
REQ-012 Port busy  output  1  high whenever the state is not IDLE; the hazard unit uses it to stall decode.
REQ-013 Port done  output  1  result valid toward writeback.
REQ-014 Port result  output  DATA_WIDTH  quotient or remainder.
REQ-015 Port rd_out  output  5  latched destination tag.

Function
REQ-016 The FSM SHALL have states IDLE, CALC and DONE.
REQ-017 In IDLE with start=1 and flush=0, the block SHALL latch the operands, funct3 and rd_in on the rising edge.
REQ-018 On that accept edge, the next state SHALL be CALC, except for special cases (REQ-022, REQ-023), which go directly to DONE.
REQ-019 start SHALL be ignored in CALC and DONE; no queuing is provided.
REQ-020 CALC SHALL run a radix-2 restoring shift-subtract on operand magnitudes for exactly 32 cycles, driven by a 6-bit counter.
REQ-021 The block SHALL then enter DONE; done rises on the 33rd rising edge after the accept edge.
REQ-022 A zero divisor SHALL take 1-cycle latency and give quotient 0xFFFFFFFF and remainder = dividend, for both signed and unsigned operations.
REQ-023 Signed overflow (dividend 0x80000000, divisor 0xFFFFFFFF, DIV/REM only) SHALL take 1-cycle latency and give quotient 0x80000000 and remainder 0.
REQ-024 For signed operations, the quotient SHALL be negated when the operand signs differ.
REQ-025 For signed operations, the remainder SHALL take the sign of the dividend, truncating toward zero.
REQ-026 All internal arithmetic SHALL be done on 32-bit magnitudes plus a 33-bit partial remainder; a magnitude of 0x80000000 is handled without overflow.
REQ-027 In DONE, done=1 and result/rd_out SHALL hold stable until ack=1.
REQ-028 On the ack edge the next state SHALL be IDLE and done SHALL fall.
REQ-029 A start in the same cycle as ack SHALL be ignored; it must be re-presented in IDLE.
REQ-030 flush=1 in any state SHALL force the next state to IDLE, with done=0 and busy=0 after that edge and no result delivered.
REQ-031 flush SHALL take priority over start and over ack.
REQ-032 rd_in=0 SHALL be computed and delivered normally; writeback discards writes to x0.
REQ-033 result and rd_out SHALL change only when a result is produced, and hold their values in IDLE.

Reset
REQ-034 Asserting rst SHALL immediately, without waiting for a clock edge, force state IDLE, counter 0, busy=0, done=0, result=0 and rd_out=0.
REQ-035 Reset mid-CALC SHALL discard the operation; no done is produced after release.
REQ-036 After rst deasserts, the first rising edge with start=1 SHALL be accepted normally.

Verification
REQ-037 DIV, 100/7, rd_in=5 -> busy=1 from the next edge; done=1 at edge 33; result=14, rd_out=5. REM on the same operands -> 2.
REQ-038 DIV, 0xFFFFFFF9(-7)/2 -> 0xFFFFFFFD. REM on the same operands -> 0xFFFFFFFF. DIVU on the same operands -> 0x7FFFFFFC.
REQ-039 DIVU 5/0 -> done at edge 1, result 0xFFFFFFFF. REMU 5/0 -> 5. DIV 0x80000000/0xFFFFFFFF -> 0x80000000. REM on those operands -> 0.
REQ-040 Hold ack=0 for 10 cycles in DONE -> done and result stay stable; ack=1 -> IDLE next edge; start during the ack cycle ignored.
REQ-041 flush asserted at CALC cycle 10 together with start -> busy=0 next edge, done never asserts, and a new start two cycles later completes correctly.
REQ-042 Assert rst between clock edges at CALC cycle 20 -> outputs zero before the next edge; no done after release.
